// File: rtl/ubbka_stream_accumulator.sv
// rtl/ubbka_stream_accumulator.sv - frame accumulator around a 12-bit Brent-Kung adder
//
// Accepts a valid/ready stream of 12-bit operands and sums each frame into a
// SUM_W = 12+HI_W bit value. The low 12 bits go through a Brent-Kung prefix
// adder (X = acc_lo, Y = in_data, carry-in 0). Its carry-out advances the
// upper HI_W-bit extension. One registered {sum, count} result is emitted per
// frame, and is held until the downstream stage accepts it.
//
// Optional feature macro: UBBKA_ACC_SAT_EN
//   defined   : the accumulator saturates to all-ones on overflow and sets a
//               sticky per-frame flag that is reported on out_ovf
//   undefined : acc_hi wraps mod 2^HI_W and out_ovf is tied to 0
//
// Ports
//   CLK        in   1      rising-edge clock
//   RSTn       in   1      asynchronous active-low reset
//   clr        in   1      synchronous frame abort (ignored while a result is held)
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      stage accepts a beat (1 while accumulating)
//   in_data    in   12     operand
//   in_last    in   1      final beat of frame
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_sum    out  SUM_W  frame sum
//   out_cnt    out  CNT_W  beats in frame (wraps silently)
//   out_ovf    out  1      frame overflowed SUM_W

module ubbka_stream_accumulator #(
    parameter int HI_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [11:0]         in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [12+HI_W-1:0]  out_sum,
    output logic [CNT_W-1:0]    out_cnt,
    output logic                out_ovf
);

    localparam int SUM_W = 12 + HI_W;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [11:0]      acc_lo;
    logic [HI_W-1:0]  acc_hi;
    logic [CNT_W-1:0] cnt;

    // 12-bit Brent-Kung adder, carry-in 0. Up-sweep builds group (g,p) at
    // nodes 1,3,7 and the block spans 8..11; down-sweep fills the remaining
    // prefixes. After both sweeps g[i] is the carry out of bit i.
    function automatic logic [12:0] bk_add12(input logic [11:0] x, input logic [11:0] y);
        logic [11:0] g;
        logic [11:0] p;
        logic [11:0] h;
        logic [12:0] s;
        g = x & y;
        p = x ^ y;
        h = p;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 12; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < 12; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        s[0] = h[0];
        for (int i = 1; i < 12; i++) begin
            s[i] = h[i] ^ g[i - 1];
        end
        s[12] = g[11];
        return s;
    endfunction

    logic [12:0]      add_s;
    logic [HI_W-1:0]  hi_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic [11:0]      new_lo;
    logic [HI_W-1:0]  new_hi;
    logic             beat;

    assign add_s   = bk_add12(acc_lo, in_data);
    assign hi_inc  = acc_hi + {{(HI_W-1){1'b0}}, add_s[12]};
    assign cnt_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign beat    = in_valid & in_ready;

`ifdef UBBKA_ACC_SAT_EN
    logic sat_q;
    logic sat_d;

    // Overflow out of SUM_W happens only when acc_hi is all-ones and the low
    // adder carries; once saturated the frame ignores further operands.
    assign sat_d  = sat_q | ((&acc_hi) & add_s[12]);
    assign new_lo = sat_d ? {12{1'b1}}   : add_s[11:0];
    assign new_hi = sat_d ? {HI_W{1'b1}} : hi_inc;
`else
    assign new_lo  = add_s[11:0];
    assign new_hi  = hi_inc;
    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (beat && in_last && !clr) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            acc_lo    <= '0;
            acc_hi    <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
`ifdef UBBKA_ACC_SAT_EN
            sat_q     <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else if (state_q == ACC) begin
            if (clr) begin
                // Abort wins over a coincident beat; the beat is consumed and lost.
                acc_lo <= '0;
                acc_hi <= '0;
                cnt    <= '0;
`ifdef UBBKA_ACC_SAT_EN
                sat_q  <= 1'b0;
`endif
            end else if (beat) begin
                if (in_last) begin
                    out_sum   <= {new_hi, new_lo};
                    out_cnt   <= cnt_inc;
                    out_valid <= 1'b1;
                    acc_lo    <= '0;
                    acc_hi    <= '0;
                    cnt       <= '0;
`ifdef UBBKA_ACC_SAT_EN
                    out_ovf   <= sat_d;
                    sat_q     <= 1'b0;
`endif
                end else begin
                    acc_lo <= new_lo;
                    acc_hi <= new_hi;
                    cnt    <= cnt_inc;
`ifdef UBBKA_ACC_SAT_EN
                    sat_q  <= sat_d;
`endif
                end
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ubbka_stream_accumulator.sv
// tb/tb_ubbka_stream_accumulator.sv - directed bench for ubbka_stream_accumulator
module tb_ubbka_stream_accumulator;

    localparam int HI_W  = 4;
    localparam int CNT_W = 8;
    localparam int SUM_W = 12 + HI_W;

    logic             CLK;
    logic             RSTn;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    ubbka_stream_accumulator #(.HI_W(HI_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          n;
        logic [47:0] beats;
        logic [15:0] exp_sum;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one beat; returns at posedge+1 after it was accepted.
    task automatic send(input logic [11:0] d, input logic last, input logic c);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        clr      = c;
        while (!in_ready && guard < 50) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed 0");
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] s, input logic [7:0] n, input logic ovf);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"},   {16'd0, out_sum},   {16'd0, s});
        check({tag, "_cnt"},   {24'd0, out_cnt},   {24'd0, n});
        check({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
        check({tag, "_inrdy_hold"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_inrdy"},     {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        vecs[0].n = 3; vecs[0].beats = {12'h000, 12'h001, 12'h800, 12'h800}; vecs[0].exp_sum = 16'h1001; vecs[0].exp_cnt = 8'd3;
        vecs[1].n = 1; vecs[1].beats = {12'h000, 12'h000, 12'h000, 12'hABC}; vecs[1].exp_sum = 16'h0ABC; vecs[1].exp_cnt = 8'd1;
        vecs[2].n = 2; vecs[2].beats = {12'h000, 12'h000, 12'h001, 12'hFFF}; vecs[2].exp_sum = 16'h1000; vecs[2].exp_cnt = 8'd2;
        vecs[3].n = 1; vecs[3].beats = {12'h000, 12'h000, 12'h000, 12'h000}; vecs[3].exp_sum = 16'h0000; vecs[3].exp_cnt = 8'd1;
        vecs[4].n = 4; vecs[4].beats = {12'hABC, 12'h789, 12'h456, 12'h123}; vecs[4].exp_sum = 16'h17BE; vecs[4].exp_cnt = 8'd4;

        RSTn      = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 12'h000;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",   {16'd0, out_sum},   32'd0);
        check("rst_cnt",   {24'd0, out_cnt},   32'd0);
        check("rst_ovf",   {31'd0, out_ovf},   32'd0);
        check("rst_inrdy", {31'd0, in_ready},  32'd1);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Table-driven frames with out_ready held high
        for (int v = 0; v < 5; v++) begin
            logic [47:0] b;
            b = vecs[v].beats;
            for (int i = 0; i < vecs[v].n; i++) begin
                send(b[12*i +: 12], (i == vecs[v].n - 1), 1'b0);
            end
            check_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt, 1'b0);
            @(posedge CLK);
            #1;
            check_idle($sformatf("vec%0d_after", v));
        end

        // T3: back-pressure holds the result stable
        out_ready = 1'b0;
        send(12'h005, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check_result($sformatf("t3_hold%0d", c), 16'h0005, 8'd1, 1'b0);
            clr = 1'b1;
            @(posedge CLK);
            #1;
            clr = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check_idle("t3_release");

        // T4: 17 x 0xFFF overflows 16 bits
        for (int i = 0; i < 17; i++) begin
            send(12'hFFF, (i == 16), 1'b0);
        end
`ifdef UBBKA_ACC_SAT_EN
        check_result("t4_sat", 16'hFFFF, 8'd17, 1'b1);
`else
        check_result("t4_wrap", 16'h0FEF, 8'd17, 1'b0);
`endif
        @(posedge CLK);
        #1;
        // Flag and accumulator must start clean in the next frame
        send(12'h001, 1'b1, 1'b0);
        check_result("t4_next", 16'h0001, 8'd1, 1'b0);
        @(posedge CLK);
        #1;

        // T5: clr coincident with the last beat drops the frame
        send(12'h123, 1'b0, 1'b0);
        send(12'h456, 1'b0, 1'b0);
        send(12'h00F, 1'b1, 1'b1);
        check_idle("t5_dropped");
        @(posedge CLK);
        #1;
        check_idle("t5_dropped2");
        send(12'h002, 1'b1, 1'b0);
        check_result("t5_next", 16'h0002, 8'd1, 1'b0);
        @(posedge CLK);
        #1;

        // T6: async reset mid-frame and during HOLD
        send(12'h100, 1'b0, 1'b0);
        send(12'h200, 1'b0, 1'b0);
        RSTn = 1'b0;
        #1;
        check("t6a_valid", {31'd0, out_valid}, 32'd0);
        check("t6a_sum",   {16'd0, out_sum},   32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        send(12'h00A, 1'b1, 1'b0);
        check_result("t6a_next", 16'h000A, 8'd1, 1'b0);
        out_ready = 1'b0;
        @(posedge CLK);
        #1;
        check_result("t6b_hold", 16'h000A, 8'd1, 1'b0);
        RSTn = 1'b0;
        #1;
        check("t6b_valid", {31'd0, out_valid}, 32'd0);
        check("t6b_sum",   {16'd0, out_sum},   32'd0);
        check("t6b_cnt",   {24'd0, out_cnt},   32'd0);
        check("t6b_inrdy", {31'd0, in_ready},  32'd1);
        @(posedge CLK);
        #1;
        RSTn      = 1'b1;
        out_ready = 1'b1;
        send(12'h003, 1'b0, 1'b0);
        send(12'h004, 1'b1, 1'b0);
        check_result("t6b_next", 16'h0007, 8'd2, 1'b0);
        @(posedge CLK);
        #1;

        // Beat counter wraps silently: 257 beats report a count of 1
        for (int i = 0; i < 257; i++) begin
            send(12'h001, (i == 256), 1'b0);
        end
        check_result("cnt_wrap", 16'h0101, 8'd1, 1'b0);
        @(posedge CLK);
        #1;
        check_idle("cnt_wrap_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
